// File: rtl/cam_init_pkg.sv
// Shared types and defaults for the camera power-up / configuration sequencer.
package cam_init_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWDN,
        S_RESET,
        S_SETTLE,
        S_CFG_RUN,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [31:0] DEF_PWDN_CYCLES       = 32'd1_000_000;
    localparam logic [31:0] DEF_RESET_CYCLES      = 32'd500_000;
    localparam logic [31:0] DEF_SETTLE_CYCLES     = 32'd2_000_000;
    localparam logic [31:0] DEF_CFG_TIMEOUT_CYCLES = 32'd50_000_000;
    localparam int          RETRY_W               = 4;

    // The timer expires when it reaches zero, so a phase of N cycles loads N-1; zero behaves as one.
    function automatic logic [31:0] phase_load(input logic [31:0] cycles);
        return (cycles == 32'd0) ? 32'd0 : cycles - 32'd1;
    endfunction

endpackage

// File: rtl/cam_init_seq_cyc_timer.sv
// 32-bit down-counter shared by every timed phase and by the configuration timeout.
module cyc_timer (
    input  logic        clk,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        expired
);

    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_val;
        end else if (count != 32'd0) begin
            count <= count - 32'd1;
        end
    end

    assign expired = (count == 32'd0);

endmodule

// File: rtl/cam_init_seq.sv
// Camera power-down/reset sequencing, configurator release and retry supervision.
module cam_init_seq
    import cam_init_pkg::*;
#(
    parameter logic [31:0]        PWDN_CYCLES        = DEF_PWDN_CYCLES,
    parameter logic [31:0]        RESET_CYCLES       = DEF_RESET_CYCLES,
    parameter logic [31:0]        SETTLE_CYCLES      = DEF_SETTLE_CYCLES,
    parameter logic [31:0]        CFG_TIMEOUT_CYCLES = DEF_CFG_TIMEOUT_CYCLES,
    parameter logic [RETRY_W-1:0] MAX_RETRY          = 4'd3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cfg_done,
    input  logic               cfg_error,
    output logic               cfg_rst,
    output logic               cam_pwdn,
    output logic               cam_rst_n,
    output logic               busy,
    output logic               init_done,
    output logic               init_fail,
    output logic [RETRY_W-1:0] retry_cnt
);

    state_t      state;
    logic        cfg_first;
    logic        tmr_load;
    logic [31:0] tmr_val;
    logic        tmr_expired;
    logic        cfg_seen;
    logic        cfg_ok;
    logic        attempt_fail;
    logic        retry_ok;

    cyc_timer u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // The configurator is still leaving reset on its first cycle, so its flags are not trusted yet.
    assign cfg_seen     = (state == S_CFG_RUN) && !cfg_first && cfg_done;
    assign cfg_ok       = cfg_seen && !cfg_error;
    assign attempt_fail = (state == S_CFG_RUN) && (cfg_seen ? cfg_error : tmr_expired);
    assign retry_ok     = (retry_cnt < MAX_RETRY);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = phase_load(PWDN_CYCLES);
        case (state)
            S_IDLE, S_DONE, S_FAIL: tmr_load = start;
            S_PWDN: begin
                tmr_load = tmr_expired;
                tmr_val  = phase_load(RESET_CYCLES);
            end
            S_RESET: begin
                tmr_load = tmr_expired;
                tmr_val  = phase_load(SETTLE_CYCLES);
            end
            S_SETTLE: begin
                tmr_load = tmr_expired;
                tmr_val  = phase_load(CFG_TIMEOUT_CYCLES);
            end
            S_CFG_RUN: tmr_load = attempt_fail && retry_ok;
            default: tmr_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cfg_first <= 1'b0;
            cfg_rst   <= 1'b1;
            cam_pwdn  <= 1'b1;
            cam_rst_n <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
            init_fail <= 1'b0;
            retry_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state     <= S_PWDN;
                        cfg_rst   <= 1'b1;
                        cam_pwdn  <= 1'b1;
                        cam_rst_n <= 1'b0;
                        busy      <= 1'b1;
                        init_done <= 1'b0;
                        init_fail <= 1'b0;
                        retry_cnt <= '0;
                    end
                end
                S_PWDN: begin
                    if (tmr_expired) begin
                        state    <= S_RESET;
                        cam_pwdn <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (tmr_expired) begin
                        state     <= S_SETTLE;
                        cam_rst_n <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (tmr_expired) begin
                        state     <= S_CFG_RUN;
                        cfg_rst   <= 1'b0;
                        cfg_first <= 1'b1;
                    end
                end
                S_CFG_RUN: begin
                    cfg_first <= 1'b0;
                    if (cfg_ok) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                    end else if (attempt_fail) begin
                        cfg_rst <= 1'b1;
                        if (retry_ok) begin
                            // Every retry is a full power cycle of the camera.
                            state     <= S_PWDN;
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            cam_pwdn  <= 1'b1;
                            cam_rst_n <= 1'b0;
                        end else begin
                            state     <= S_FAIL;
                            busy      <= 1'b0;
                            init_fail <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
